sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 134 +++++++++++++
 tb/tb_sram_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two
// halfword phases (low then high), freezing the pipeline via ready meanwhile.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req;
    logic [16:0] req_idx;
    logic        unused_addr_bits;

    // Data memory starts at byte 1024; the halfword pair for a word sits at
    // {index,0}/{index,1}. Subtracting 256 from the word address is the same
    // as (address - 1024) >> 2 truncated to 17 bits.
    assign req_idx          = address[18:2] - 17'd256;
    assign unused_addr_bits = ^{address[31:19], address[1:0]};
    assign req              = wr_en | rd_en;
    assign read_data        = rdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 17'd0;
            data_q  <= 32'd0;
            is_wr_q <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Handshake: ready is high when the controller can retire the current MEM
    // access this cycle (idle with no request, or DONE). A request seen in
    // IDLE is captured immediately; inputs are ignored until the next IDLE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        sram_addr   = 18'd0;
        sram_dq_out = 16'd0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state_q)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = LOW;
                    cnt_d   = 4'd0;
                    idx_d   = req_idx;
                    data_d  = write_data;
                    is_wr_d = wr_en;
                end
            end
            LOW: begin
                sram_addr = {idx_q, 1'b0};
                if (is_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[15:0];
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    cnt_d   = 4'd0;
                    if (!is_wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                sram_addr = {idx_q, 1'b1};
                if (is_wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[31:16];
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!is_wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and random loads/stores against a
// behavioural halfword SRAM and a word-level reference memory.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_rd;
    logic [15:0] ref_half [0:1023];

    sram_controller #(.WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Power-up content of the SRAM, known to both the SRAM model and the reference.
    function automatic logic [15:0] init_half(input logic [9:0] i);
        logic [31:0] v;
        v = 32'(i) * 32'd40503 + 32'h1234;
        return v[15:0];
    endfunction

    // Slow SRAM model: a halfword is stored only after the write strobe has
    // been held for a full phase at the same address.
    logic [15:0] sram_mem [0:1023];
    bit          written  [0:1023];
    logic [17:0] wr_addr_q;
    int          wr_cnt = 0;

    assign sram_dq_in = written[sram_addr[9:0]] ? sram_mem[sram_addr[9:0]] : init_half(sram_addr[9:0]);

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            if (wr_cnt != 0 && sram_addr == wr_addr_q) begin
                wr_cnt <= wr_cnt + 1;
                if (wr_cnt + 1 == W) begin
                    sram_mem[sram_addr[9:0]] <= sram_dq_out;
                    written[sram_addr[9:0]]  <= 1'b1;
                end
            end else begin
                wr_cnt    <= 1;
                wr_addr_q <= sram_addr;
                if (W == 1) begin
                    sram_mem[sram_addr[9:0]] <= sram_dq_out;
                    written[sram_addr[9:0]]  <= 1'b1;
                end
            end
        end else begin
            wr_cnt <= 0;
        end
    end

    // Reference address rule: halfword address of byte address a.
    function automatic logic [17:0] exp_haddr(input logic [31:0] a, input bit hi);
        logic [31:0] r;
        r = (((a - 32'd1024) >> 2) % 32'd131072) * 32'd2 + 32'(hi);
        return r[17:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            rd_en = 1'b0;
            #1;
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
            chk("idle_oe", 32'(sram_dq_oe), 32'd0);
            chk("idle_addr", 32'(sram_addr), 32'd0);
        end
    endtask

    task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] d, input bit drop, input string tag);
        bit          is_wr;
        logic [17:0] ha;
        logic [17:0] lo_a;
        logic [17:0] hi_a;
        logic [15:0] eq;
        is_wr = wr;
        lo_a  = exp_haddr(a, 1'b0);
        hi_a  = exp_haddr(a, 1'b1);
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        address = a;
        write_data = d;
        #1;
        chk({tag, "_c0_ready"}, 32'(ready), 32'd0);
        if (!is_wr) exp_q.push_back({ref_half[hi_a[9:0]], ref_half[lo_a[9:0]]});
        for (int c = 1; c <= 2 * W; c++) begin
            @(negedge clk);
            if (drop && c == 1) begin
                wr_en = 1'b0;
                rd_en = 1'b0;
                address = $urandom;
                write_data = $urandom;
            end
            #1;
            ha = (c > W) ? hi_a : lo_a;
            eq = (c > W) ? d[31:16] : d[15:0];
            chk({tag, "_addr"}, 32'(sram_addr), 32'(ha));
            chk({tag, "_we_n"}, 32'(sram_we_n), 32'(!is_wr));
            chk({tag, "_oe"}, 32'(sram_dq_oe), 32'(is_wr));
            chk({tag, "_busy_ready"}, 32'(ready), 32'd0);
            if (is_wr) chk({tag, "_dq_out"}, 32'(sram_dq_out), 32'(eq));
        end
        @(negedge clk);
        #1;
        chk({tag, "_done_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_done_oe"}, 32'(sram_dq_oe), 32'd0);
        chk({tag, "_done_addr"}, 32'(sram_addr), 32'd0);
        if (is_wr) begin
            ref_half[lo_a[9:0]] = d[15:0];
            ref_half[hi_a[9:0]] = d[31:16];
        end else begin
            exp_rd = exp_q.pop_front();
        end
        chk({tag, "_read_data"}, read_data, exp_rd);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        chk({tag, "_oe"}, 32'(sram_dq_oe), 32'd0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'd0);
        chk({tag, "_dq_out"}, 32'(sram_dq_out), 32'd0);
        chk({tag, "_read_data"}, read_data, 32'd0);
    endtask

    // directed sequence, then random traffic
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [17:0] ha;
        int          op;
        for (int i = 0; i < 1024; i++) ref_half[i] = init_half(10'(i));
        exp_rd = 32'd0;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        address = 32'd0;
        write_data = 32'd0;

        repeat (3) @(negedge clk);
        #1;
        reset_checks("in_reset");
        @(negedge clk);
        rst = 1'b1;
        #1;
        reset_checks("post_reset");

        idle(10);

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b1, "wr_beef");
        idle(1);
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, "rd_beef");
        chk("rd_beef_value", read_data, 32'hDEADBEEF);

        access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, "wr_b2b");
        access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, "rd_b2b");
        chk("rd_b2b_value", read_data, 32'h12345678);

        access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, 1'b1, "wr_both");
        chk("wr_both_rd_kept", read_data, 32'h12345678);
        access(1'b0, 1'b1, 32'd1033, 32'h0, 1'b1, "rd_both");

        access(1'b1, 1'b0, 32'h8000_0400, 32'h0BADCAFE, 1'b1, "wr_alias");
        access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, "rd_alias");
        access(1'b1, 1'b0, 32'd0, 32'h600DF00D, 1'b1, "wr_wrap");
        access(1'b0, 1'b1, 32'd0, 32'h0, 1'b0, "rd_wrap");
        idle(2);

        // Abort a write with reset during its first HIGH cycle.
        a = 32'd1024 + 32'd4 * 32'd300;
        d = 32'hCAFEF00D;
        @(negedge clk);
        wr_en = 1'b1;
        address = a;
        write_data = d;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            wr_en = 1'b0;
        end
        #1;
        ha = exp_haddr(a, 1'b1);
        chk("abort_high_addr", 32'(sram_addr), 32'(ha));
        chk("abort_high_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        reset_checks("abort_reset");
        rst = 1'b1;
        exp_rd = 32'd0;
        ha = exp_haddr(a, 1'b0);
        ref_half[ha[9:0]] = d[15:0];
        idle(1);
        access(1'b0, 1'b1, a, 32'h0, 1'b1, "rd_abort");

        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            a = 32'd1024 + 32'd4 * $urandom_range(0, 255) + $urandom_range(0, 3);
            d = $urandom;
            access(op != 1, op != 0, a, d, 1'($urandom_range(0, 1)), "rand");
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
